// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory responder.
// Holds the responder state encoding, bus direction constants and the address check.
// Purely declarative: no timing or backpressure of its own.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RESPOND = 2'd3
    } mem_state_t;

    localparam logic MEM_WR = 1'b1;
    localparam logic MEM_RD = 1'b0;

    // Word-aligned and inside the 4*depth byte window; widened so large depths cannot overflow.
    function automatic logic mem_addr_ok(input logic [31:0] addr, input int unsigned depth);
        logic [33:0] limit;
        limit = 34'(depth) << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Single-port word RAM: synchronous write, synchronous registered read.
// Latency: read data appears the cycle after re_i; write lands on the we_i edge.
// No backpressure: one access per cycle, caller guarantees we_i and re_i are exclusive.
module mips_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Registered read port, cleared by reset so the bus never shows stale data after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_mem_responder.sv
// Target side of the CPU data-memory bus: captures a request, waits, accesses the RAM, pulses mem_ready.
// Latency: WAIT_CYCLES+2 cycles from the request edge to mem_ready; read data valid with mem_ready.
// No queue: mem_req outside IDLE is ignored; MIPS_MEM_ERRCHK_EN enables address error reporting.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        MemRWPin,
    input  logic [31:0] addressBus,
    inout  wire  [31:0] dataBus,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          rw_q, rw_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          req_err;
    logic [31:0]   rdata;
    logic          array_we, array_re, drive_en;

`ifdef MIPS_MEM_ERRCHK_EN
    assign req_err = !mem_addr_ok(addressBus, DEPTH);
`else
    // Without checking, the byte offset and high bits simply wrap the index.
    assign req_err = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addressBus[31:AW+2], addressBus[1:0]};
`endif

    // State, wait counter and captured request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rw_q    <= MEM_RD;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state, request capture and per-state outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        array_we  = 1'b0;
        array_re  = 1'b0;
        drive_en  = 1'b0;
        mem_ready = 1'b0;
        mem_err   = 1'b0;
        mem_busy  = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    idx_d   = addressBus[AW+1:2];
                    rw_d    = MemRWPin;
                    wdata_d = dataBus;
                    err_d   = req_err;
                    cnt_d   = CW'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The counter value seen here is the number of WAIT cycles still to spend.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                array_we = (rw_q == MEM_WR) && !err_q;
                array_re = (rw_q == MEM_RD) && !err_q;
                state_d  = ST_RESPOND;
            end
            ST_RESPOND: begin
                mem_ready = 1'b1;
                mem_err   = err_q;
                drive_en  = (rw_q == MEM_RD);
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    mips_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .we_i    (array_we),
        .re_i    (array_re),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

    // Drive only during RESPOND of a read; an errored read presents zero.
    assign dataBus = drive_en ? (err_q ? 32'h0 : rdata) : 32'hz;

endmodule

// File: tb/tb_mips_mem_responder.sv
module tb_mips_mem_responder;

`ifdef MIPS_MEM_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, rw, cpu_en;
    logic [31:0] addr_s [2];
    logic [31:0] cpu_drv [2];
    logic [1:0]  rdy, errv, busy;
    wire  [31:0] bus0, bus1;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl_mem   [256];
    bit          mdl_known [256];

    always #5 clk = ~clk;

    assign bus0 = cpu_en[0] ? cpu_drv[0] : 32'hz;
    assign bus1 = cpu_en[1] ? cpu_drv[1] : 32'hz;

    mips_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .mem_req(req[0]), .MemRWPin(rw[0]),
        .addressBus(addr_s[0]), .dataBus(bus0),
        .mem_ready(rdy[0]), .mem_err(errv[0]), .mem_busy(busy[0])
    );

    mips_mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .mem_req(req[1]), .MemRWPin(rw[1]),
        .addressBus(addr_s[1]), .dataBus(bus1),
        .mem_ready(rdy[1]), .mem_err(errv[1]), .mem_busy(busy[1])
    );

    function automatic logic [31:0] bus_val(input int i);
        return (i == 0) ? bus0 : bus1;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One transaction; returns at the negedge of the mem_ready cycle.
    task automatic txn(input int i, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err, output int lat, output int busy_n);
        @(negedge clk);
        req[i] = 1'b1; rw[i] = wr; addr_s[i] = a; cpu_drv[i] = wd; cpu_en[i] = wr;
        @(negedge clk);
        req[i] = 1'b0; cpu_en[i] = 1'b0;
        lat = 1; busy_n = 0;
        while (!rdy[i] && lat < 30) begin
            if (busy[i]) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (busy[i]) busy_n++;
        rd  = bus_val(i);
        err = errv[i];
        if (!rdy[i]) begin
            total++; bad++;
            $display("FAIL timeout: no mem_ready on instance %0d within %0d cycles", i, lat);
        end
    endtask

    // Cycle after RESPOND: pulse gone, idle, bus released (CPU drives 0 and must see 0).
    task automatic post_check(input int i);
        @(negedge clk);
        cpu_en[i] = 1'b1; cpu_drv[i] = 32'h0;
        #1;
        check("post_ready", 32'(rdy[i]), 32'h0);
        check("post_busy",  32'(busy[i]), 32'h0);
        check("bus_release", bus_val(i), 32'h0);
        cpu_en[i] = 1'b0;
    endtask

    // Reference model for the 256-word instance: checks a completed transaction and updates memory.
    task automatic model_txn(input string nm, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input bit err);
        bit ok;
        bit exp_err;
        int idx;
        ok      = (a % 4 == 0) && (a < 32'd1024);
        exp_err = ERRCHK && !ok;
        idx     = int'((a / 4) % 256);
        check({nm, "_err"}, 32'(err), 32'(exp_err));
        if (wr) begin
            if (!exp_err) begin
                mdl_mem[idx]   = wd;
                mdl_known[idx] = 1'b1;
            end
        end else if (exp_err) begin
            check({nm, "_rd0"}, rd, 32'h0);
        end else if (mdl_known[idx]) begin
            check({nm, "_rd"}, rd, mdl_mem[idx]);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          err;
        int          lat, busy_n, pulses;
        logic [31:0] a, wd;
        bit          wr;

        for (int k = 0; k < 256; k++) mdl_known[k] = 1'b0;
        reset = 1'b1; req = '0; rw = '0; cpu_en = '0;
        addr_s[0] = '0; addr_s[1] = '0; cpu_drv[0] = '0; cpu_drv[1] = '0;

        tbl[0] = '{1'b1, 32'h0,   32'hA5A5A5A5, 32'h0, 1'b0};
        tbl[1] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0, 1'b0};
        tbl[2] = '{1'b0, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 32'h13,  32'h11111111, 32'h0, ERRCHK};
        tbl[4] = '{1'b0, 32'h10,  32'h0, ERRCHK ? 32'hDEADBEEF : 32'h11111111, 1'b0};
        tbl[5] = '{1'b0, 32'h400, 32'h0, ERRCHK ? 32'h0 : 32'hA5A5A5A5, ERRCHK};
        tbl[6] = '{1'b1, 32'h20,  32'h00C0FFEE, 32'h0, 1'b0};

        // Reset state on both instances.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(rdy[i]), 32'h0);
            check("rst_err",   32'(errv[i]), 32'h0);
            check("rst_busy",  32'(busy[i]), 32'h0);
        end
        cpu_en = 2'b11; #1;
        check("rst_bus0", bus0, 32'h0);
        check("rst_bus1", bus1, 32'h0);
        cpu_en = 2'b00;
        @(negedge clk);
        reset = 1'b0;

        // Directed table on the default instance.
        for (int v = 0; v < 7; v++) begin
            txn(0, tbl[v].wr, tbl[v].a, tbl[v].wd, rd, err, lat, busy_n);
            check("tbl_latency", 32'(lat), 32'd4);
            check("tbl_busy_cycles", 32'(busy_n), 32'd4);
            check("tbl_err", 32'(err), 32'(tbl[v].exp_err));
            if (!tbl[v].wr) check("tbl_rdata", rd, tbl[v].exp_rd);
            model_txn("tbl_model", tbl[v].wr, tbl[v].a, tbl[v].wd, rd, err);
            post_check(0);
        end

        // Request while busy: the poke in WAIT must be ignored.
        @(negedge clk);
        req[0] = 1'b1; rw[0] = 1'b0; addr_s[0] = 32'h10;
        @(negedge clk);
        rw[0] = 1'b1; addr_s[0] = 32'h20; cpu_drv[0] = 32'hBAD0BAD0; cpu_en[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0; cpu_en[0] = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (rdy[0]) begin
                pulses++;
                check("busy_rd", bus0, mdl_mem[4]);
            end
            @(negedge clk);
        end
        check("busy_pulses", 32'(pulses), 32'd1);
        txn(0, 1'b0, 32'h20, 32'h0, rd, err, lat, busy_n);
        check("busy_untouched", rd, 32'h00C0FFEE);

        // Back-to-back: this request lands in the cycle right after RESPOND.
        txn(0, 1'b1, 32'h8, 32'h55AA55AA, rd, err, lat, busy_n);
        model_txn("b2b_w", 1'b1, 32'h8, 32'h55AA55AA, rd, err);
        txn(0, 1'b0, 32'h8, 32'h0, rd, err, lat, busy_n);
        check("b2b_latency", 32'(lat), 32'd4);
        check("b2b_rd", rd, 32'h55AA55AA);
        post_check(0);

        // Reset in WAIT during a write: abandoned, memory unchanged.
        @(negedge clk);
        req[0] = 1'b1; rw[0] = 1'b1; addr_s[0] = 32'h8; cpu_drv[0] = 32'h12345678; cpu_en[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0; cpu_en[0] = 1'b0;
        reset = 1'b1; #1;
        check("rstw_ready", 32'(rdy[0]), 32'h0);
        check("rstw_err",   32'(errv[0]), 32'h0);
        check("rstw_busy",  32'(busy[0]), 32'h0);
        cpu_en[0] = 1'b1; cpu_drv[0] = 32'h0; #1;
        check("rstw_bus", bus0, 32'h0);
        cpu_en[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        txn(0, 1'b0, 32'h8, 32'h0, rd, err, lat, busy_n);
        check("rstw_keep", rd, 32'h55AA55AA);
        post_check(0);

        // Reset just after the ACCESS edge: write persists, no ready pulse.
        @(negedge clk);
        req[0] = 1'b1; rw[0] = 1'b1; addr_s[0] = 32'h8; cpu_drv[0] = 32'h0BADF00D; cpu_en[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0; cpu_en[0] = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rsta_ready", 32'(rdy[0]), 32'h0);
        check("rsta_busy",  32'(busy[0]), 32'h0);
        reset = 1'b0;
        mdl_mem[2] = 32'h0BADF00D;
        txn(0, 1'b0, 32'h8, 32'h0, rd, err, lat, busy_n);
        check("rsta_persist", rd, 32'h0BADF00D);
        post_check(0);

        // Zero-wait instance (DEPTH=16).
        txn(1, 1'b1, 32'h0, 32'hCAFEF00D, rd, err, lat, busy_n);
        check("w0_wr_latency", 32'(lat), 32'd2);
        post_check(1);
        txn(1, 1'b0, 32'h0, 32'h0, rd, err, lat, busy_n);
        check("w0_rd_latency", 32'(lat), 32'd2);
        check("w0_busy_cycles", 32'(busy_n), 32'd2);
        check("w0_rd", rd, 32'hCAFEF00D);
        post_check(1);
        txn(1, 1'b0, 32'h40, 32'h0, rd, err, lat, busy_n);
        check("w0_wrap_err", 32'(err), 32'(ERRCHK));
        check("w0_wrap_rd", rd, ERRCHK ? 32'h0 : 32'hCAFEF00D);
        post_check(1);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            int r;
            r  = int'($urandom_range(0, 9));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (r < 7)       a = 32'($urandom_range(0, 255)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            else             a = 32'($urandom_range(256, 4095)) * 4;
            txn(0, wr, a, wd, rd, err, lat, busy_n);
            check("rnd_latency", 32'(lat), 32'd4);
            model_txn("rnd", wr, a, wd, rd, err);
            if ($urandom_range(0, 1) == 1) post_check(0);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
